// File: rtl/day3_pkg.sv
// Shared types and constants for the bank-select streaming core.
package day3_pkg;

    localparam int DIGIT_W         = 4;
    localparam int DEF_MAX_K       = 15;
    localparam int DEF_MAX_LEN     = 255;
    localparam int DEF_LINES_W     = 12;
    localparam int DEF_SUM_W       = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_EVAL,
        ST_CONV,
        ST_ACC,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_PICK_ZERO,
        ERR_PICK_MAX,
        ERR_PICK_LEN,
        ERR_LEN_MAX,
        ERR_LINES_ZERO,
        ERR_DIGIT
    } err_cause_t;

    // Classifies an offered configuration; ERR_NONE means it can be accepted.
    // Arguments are plain ints so that limit checks stay meaningful for any
    // port width chosen by the parameters.
    function automatic err_cause_t cfg_check(input int len, input int pick,
                                             input int lines, input int max_k,
                                             input int max_len);
        err_cause_t cause;
        cause = ERR_NONE;
        if (pick == 0)          cause = ERR_PICK_ZERO;
        else if (pick > max_k)  cause = ERR_PICK_MAX;
        else if (pick > len)    cause = ERR_PICK_LEN;
        else if (len > max_len) cause = ERR_LEN_MAX;
        else if (lines == 0)    cause = ERR_LINES_ZERO;
        return cause;
    endfunction

endpackage

// File: rtl/digit_stack.sv
// Small LIFO of decimal digits with an extra indexed read port used while
// converting the kept digits (bottom first) into a binary value.
module digit_stack
    import day3_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_K,
    localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               i_clear,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [DIGIT_W-1:0] i_data,
    output logic [DEPTH_W-1:0] o_depth,
    output logic [DIGIT_W-1:0] o_top,
    input  logic [DEPTH_W-1:0] i_rd_idx,
    output logic [DIGIT_W-1:0] o_rd_data
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    logic [DIGIT_W-1:0] r_mem [DEPTH];
    logic [DEPTH_W-1:0] r_depth;
    logic [DEPTH_W-1:0] w_top_idx;

    // Depth pointer; pushing and popping in one cycle is a caller bug.
    always_ff @(posedge clk) begin
        if (srst || i_clear) begin
            r_depth <= '0;
        end else begin
            assert (!(i_push && i_pop));
            if (i_push && (r_depth < DEPTH_MAX))
                r_depth <= r_depth + DEPTH_W'(1);
            else if (i_pop && (r_depth != '0))
                r_depth <= r_depth - DEPTH_W'(1);
        end
    end

    // Entry storage; a push writes the slot just above the current top.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (i_push && (r_depth == DEPTH_W'(i)))
                    r_mem[i] <= i_data;
        end
    end

    assign w_top_idx = r_depth - DEPTH_W'(1);
    assign o_depth   = r_depth;
    assign o_top     = (r_depth != '0) ? r_mem[w_top_idx] : '0;
    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/bank_select_core.sv
// Streams lines of decimal digits, keeps the largest K-digit subsequence of
// each line with a monotonic stack, converts it to binary and sums N lines.
module bank_select_core
    import day3_pkg::*;
#(
    parameter int MAX_K   = DEF_MAX_K,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LINES_W = DEF_LINES_W,
    parameter int SUM_W   = DEF_SUM_W,
    localparam int PICK_W = $clog2(MAX_K + 1),
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [PICK_W-1:0]  cfg_pick,
    input  logic [LINES_W-1:0] cfg_lines,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT_W-1:0] in_digit,
    output logic               line_valid,
    output logic [SUM_W-1:0]   line_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SUM_W-1:0]   out_sum,
    output logic               err
);

    localparam int AW = LEN_W + 1;

    state_t               r_state, w_state_next;
    logic [LEN_W-1:0]     r_len, r_pos;
    logic [PICK_W-1:0]    r_pick, r_conv_idx;
    logic [LINES_W-1:0]   r_lines, r_line_cnt;
    logic [DIGIT_W-1:0]   r_hold;
    logic [SUM_W-1:0]     r_val, r_sum;
    logic                 r_err;

    err_cause_t           w_cfg_cause;
    logic                 w_cfg_ok, w_pop, w_push, w_clear, w_pos_last, w_conv_last;
    logic [LEN_W-1:0]     w_rem;
    logic [AW-1:0]        w_avail;
    logic [PICK_W-1:0]    w_depth;
    logic [DIGIT_W-1:0]   w_top, w_rd_digit;

    assign w_cfg_cause = cfg_check(int'(cfg_len), int'(cfg_pick), int'(cfg_lines),
                                   MAX_K, MAX_LEN);
    assign w_cfg_ok    = (w_cfg_cause == ERR_NONE);

    // A popped entry is only worth dropping if enough digits remain to refill
    // the stack to K: (depth-1) + remaining >= K.
    assign w_rem       = r_len - r_pos;
    assign w_avail     = AW'(w_rem) + AW'(w_depth) - AW'(1);
    assign w_pop       = (r_state == ST_EVAL) && (w_depth != '0) &&
                         (w_top < r_hold) && (w_avail >= AW'(r_pick));
    assign w_push      = (r_state == ST_EVAL) && !w_pop && (w_depth < r_pick);
    assign w_clear     = ((r_state == ST_IDLE) && cfg_valid && w_cfg_ok) ||
                         (r_state == ST_ACC);
    assign w_pos_last  = ((r_pos + LEN_W'(1)) == r_len);
    assign w_conv_last = (r_conv_idx == (r_pick - PICK_W'(1)));

    digit_stack #(.DEPTH(MAX_K)) u_stack (
        .clk       (sysclk),
        .srst      (rst),
        .i_clear   (w_clear),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (r_hold),
        .o_depth   (w_depth),
        .o_top     (w_top),
        .i_rd_idx  (r_conv_idx),
        .o_rd_data (w_rd_digit)
    );

    // State register.
    always_ff @(posedge sysclk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (cfg_valid && w_cfg_ok) w_state_next = ST_RUN;
            ST_RUN:  if (in_valid) w_state_next = ST_EVAL;
            ST_EVAL: if (!w_pop) w_state_next = w_pos_last ? ST_CONV : ST_RUN;
            ST_CONV: if (w_conv_last) w_state_next = ST_ACC;
            ST_ACC:  w_state_next = ((r_line_cnt + LINES_W'(1)) == r_lines) ? ST_DONE : ST_RUN;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode from state and datapath registers.
    always_comb begin
        cfg_ready  = (r_state == ST_IDLE) && !rst;
        in_ready   = (r_state == ST_RUN);
        line_valid = (r_state == ST_ACC);
        line_value = (r_state == ST_ACC) ? r_val : '0;
        out_valid  = (r_state == ST_DONE);
        out_sum    = r_sum;
        err        = r_err;
    end

    // Datapath: configuration latch, digit hold, conversion and accumulation.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_len      <= '0;
            r_pick     <= '0;
            r_lines    <= '0;
            r_line_cnt <= '0;
            r_pos      <= '0;
            r_conv_idx <= '0;
            r_hold     <= '0;
            r_val      <= '0;
            r_sum      <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (!w_cfg_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_len      <= cfg_len;
                            r_pick     <= cfg_pick;
                            r_lines    <= cfg_lines;
                            r_line_cnt <= '0;
                            r_pos      <= '0;
                            r_conv_idx <= '0;
                            r_val      <= '0;
                            r_sum      <= '0;
                            r_err      <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        if (in_digit > 4'd9) begin
                            r_err  <= 1'b1;
                            r_hold <= '0;
                        end else begin
                            r_hold <= in_digit;
                        end
                    end
                end
                ST_EVAL: begin
                    if (!w_pop) r_pos <= r_pos + LEN_W'(1);
                end
                ST_CONV: begin
                    r_val      <= (r_val << 3) + (r_val << 1) + SUM_W'(w_rd_digit);
                    r_conv_idx <= r_conv_idx + PICK_W'(1);
                end
                ST_ACC: begin
                    r_sum      <= r_sum + r_val;
                    r_line_cnt <= r_line_cnt + LINES_W'(1);
                    r_pos      <= '0;
                    r_conv_idx <= '0;
                    r_val      <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_select_core.sv
// Directed bench for bank_select_core: fixed digit lines with hand-computed
// per-line values and sums, configuration errors, bad digits, mid-line reset
// and output back-pressure.
module tb_bank_select_core;

    logic        sysclk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_len;
    logic [3:0]  cfg_pick;
    logic [11:0] cfg_lines;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic        line_valid;
    logic [63:0] line_value;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        err;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] lv_q [$];

    bank_select_core dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_len    (cfg_len),
        .cfg_pick   (cfg_pick),
        .cfg_lines  (cfg_lines),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_digit   (in_digit),
        .line_valid (line_valid),
        .line_value (line_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .err        (err)
    );

    always #5 sysclk = ~sysclk;

    // Record every per-line result pulse.
    always @(negedge sysclk) begin
        if (line_valid) lv_q.push_back(line_value);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-20s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_cfg(input int len, input int pick, input int lines);
        for (int i = 0; i < 200 && !cfg_ready; i++) tick();
        check("cfg_ready_wait", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_len   = 8'(len);
        cfg_pick  = 4'(pick);
        cfg_lines = 12'(lines);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        for (int i = 0; i < 200 && !in_ready; i++) tick();
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_digit = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_digit(4'(s[i] - 8'd48));
    endtask

    task automatic wait_out();
        for (int i = 0; i < 2000 && !out_valid; i++) tick();
        check("out_valid_wait", out_valid, 1);
    endtask

    initial begin
        logic [63:0] exp_k2  [4];
        logic [63:0] exp_k12 [4];
        string       lines   [4];
        lines[0] = "987654321111111";
        lines[1] = "811111111111119";
        lines[2] = "234234234234278";
        lines[3] = "818181911112111";
        exp_k2[0] = 64'd98;  exp_k2[1] = 64'd89;  exp_k2[2] = 64'd78;  exp_k2[3] = 64'd92;
        exp_k12[0] = 64'd987654321111; exp_k12[1] = 64'd811111111119;
        exp_k12[2] = 64'd434234234278; exp_k12[3] = 64'd888911112111;

        rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0; cfg_pick = '0; cfg_lines = '0;
        in_valid = 1'b0; in_digit = '0; out_ready = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("cfg_ready_in_rst", cfg_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_err", err, 0);
        check("rst_line_valid", line_valid, 0);
        check("rst_line_value", line_value, 0);

        // K=2 over four lines.
        lv_q.delete();
        do_cfg(15, 2, 4);
        check("a_in_ready", in_ready, 1);
        for (int l = 0; l < 4; l++) send_line(lines[l]);
        wait_out();
        check("a_lines_n", 64'(lv_q.size()), 4);
        for (int l = 0; l < 4 && l < lv_q.size(); l++) check("a_line_value", lv_q[l], exp_k2[l]);
        check("a_out_sum", out_sum, 357);
        check("a_err", err, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("a_out_valid_off", out_valid, 0);
        check("a_cfg_ready", cfg_ready, 1);
        check("a_sum_kept_idle", out_sum, 357);

        // K=12 over the same lines, out_ready held high through DONE.
        lv_q.delete();
        do_cfg(15, 12, 4);
        out_ready = 1'b1;
        for (int l = 0; l < 4; l++) send_line(lines[l]);
        wait_out();
        check("b_out_sum", out_sum, 64'd3121910778619);
        check("b_lines_n", 64'(lv_q.size()), 4);
        for (int l = 0; l < 4 && l < lv_q.size(); l++) check("b_line_value", lv_q[l], exp_k12[l]);
        tick();
        check("b_out_valid_off", out_valid, 0);
        check("b_cfg_ready", cfg_ready, 1);
        out_ready = 1'b0;

        // Configuration errors.
        do_cfg(12, 13, 1);
        check("c_err_k_gt_l", err, 1);
        check("c_cfg_ready", cfg_ready, 1);
        check("c_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("c_err_rst", err, 0);
        do_cfg(12, 0, 1);
        check("c_err_k0", err, 1);
        check("c_in_ready_k0", in_ready, 0);
        check("c_cfg_ready_k0", cfg_ready, 1);
        do_cfg(4, 2, 1);
        check("c_err_cleared", err, 0);
        check("c_in_ready_ok", in_ready, 1);

        // Out-of-range digit treated as 0 and flagged.
        lv_q.delete();
        send_digit(4'd1);
        send_digit(4'd1);
        send_digit(4'hA);
        check("d_err_digit", err, 1);
        send_digit(4'd1);
        wait_out();
        check("d_lines_n", 64'(lv_q.size()), 1);
        if (lv_q.size() > 0) check("d_line_value", lv_q[0], 11);
        check("d_out_sum", out_sum, 11);
        check("d_err_sticky", err, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // K==L keeps the whole line.
        lv_q.delete();
        do_cfg(3, 3, 1);
        send_line("507");
        wait_out();
        if (lv_q.size() > 0) check("e_line_value", lv_q[0], 507);
        check("e_out_sum", out_sum, 507);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while EVAL is popping, after one line has been accumulated.
        lv_q.delete();
        do_cfg(15, 2, 2);
        send_line(lines[0]);
        send_digit(4'd1);
        send_digit(4'd1);
        check("f_sum_before", out_sum, 98);
        send_digit(4'd2);
        check("f_in_ready_eval", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("f_cfg_ready", cfg_ready, 1);
        check("f_in_ready", in_ready, 0);
        check("f_out_valid", out_valid, 0);
        check("f_out_sum", out_sum, 0);
        check("f_err", err, 0);
        check("f_line_valid", line_valid, 0);
        check("f_line_value", line_value, 0);

        // Fresh run, then hold off the consumer for 50 cycles.
        lv_q.delete();
        do_cfg(15, 2, 1);
        send_line(lines[0]);
        wait_out();
        if (lv_q.size() > 0) check("g_line_value", lv_q[0], 98);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("g_out_valid_hold", out_valid, 1);
            check("g_out_sum_hold", out_sum, 98);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("g_out_valid_off", out_valid, 0);
        check("g_cfg_ready", cfg_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bank_select_core.md
# bank_select_core

Parametrised streaming core that, for each line of decimal digits, selects the lexicographically largest K-digit subsequence and order-preserving maximum, converts it to binary, and accumulates a running sum over N lines. It sits between the UART receive/header parser (which supplies line length, pick count K and line count) and the UART transmit serialiser (which sends the 64-bit sum as 8 bytes). It generalises the fixed-K, fixed-length selector to run-time K, line length and line count up to parameter limits. It adds a per-line result tap and an error flag.

## Interface
- MAX_K, 15: maximum digits picked per line; PICK_W = $clog2(MAX_K+1)
- MAX_LEN, 255: maximum digits per line; LEN_W = $clog2(MAX_LEN+1)
- LINES_W, 12: width of line count
- SUM_W, 64: width of line value and accumulated sum
- sysclk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  high only in IDLE
- cfg_len  in  LEN_W  digits per line (L)
- cfg_pick  in  PICK_W  digits to select (K)
- cfg_lines  in  LINES_W  number of lines (N)
- in_valid  in  1  digit offered
- in_ready  out  1  high only in RUN
- in_digit  in  4  digit value 0..9
- line_valid  out  1  one-cycle pulse per completed line
- line_value  out  SUM_W  binary value of selected K digits, valid with line_valid
- out_valid  out  1  final sum available
- out_ready  in  1  consumer accepts sum
- out_sum  out  SUM_W  accumulated sum
- err  out  1  sticky error, cleared only by rst or next accepted cfg

## Operation
- States: IDLE, RUN, EVAL, CONV, ACC, DONE.
- IDLE: cfg_valid&&cfg_ready latches L, K, N.
  - Rejected with err=1, staying IDLE, if K==0, K>MAX_K, K>L, L>MAX_LEN, or N==0.
  - Otherwise: clear sum, line count, position, stack depth and err; go to RUN.
- RUN: in_valid&&in_ready captures the digit into hold, then go to EVAL. A digit >9 sets err and is captured as 0.
- EVAL: rem = L − pos, where pos is the 0-based index of the held digit.
  - Pop condition: depth>0, top<hold, and (depth−1)+rem ≥ K.
  - While the pop condition holds, pop one entry per cycle.
  - Otherwise, push hold if depth<K (else drop it) and increment pos.
  - Next state: CONV if pos reaches L, else RUN.
- CONV: val starts at 0; val = val*10 + stack[j] for j = 0..K−1, bottom first. One digit per cycle; *10 computed as (val<<3)+(val<<1), truncated to SUM_W.
- ACC: sum += val, modulo 2^SUM_W; line_valid pulses with line_value=val; increment line count; clear pos, depth and val.
  - Next state: DONE if line count == N, else RUN.
- DONE: out_valid=1 and out_sum stable until out_valid&&out_ready, then go to IDLE. out_sum keeps its value in IDLE until the next cfg is accepted.
- cfg_valid outside IDLE and in_valid outside RUN are ignored.

## Timing
- Reset values: cfg_ready=0 during rst, 1 the cycle after. All other outputs are 0: in_ready, line_valid, line_value, out_valid, out_sum, err.
- Per digit cost: 1 RUN cycle + 1 EVAL cycle + 1 cycle per pop.
- Line end to line_valid: K CONV cycles + 1 (ACC).
- Last ACC to out_valid: 1 cycle.
- rst asserted in any state: next cycle is IDLE with reset values. Partial line and sum are discarded.
- out_ready held high in DONE: handshake completes in the first DONE cycle.
- K==L: no pops; every digit is pushed; value equals the line itself.

## Structure
- Package day3_pkg: state enum, DIGIT_W=4, default parameter constants, error-cause encoding.
- Sub-module digit_stack: LIFO of MAX_K × 4-bit entries.
  - Interface: push, pop, depth, top, and indexed read port for CONV.
  - Simultaneous push and pop is illegal and asserted against.

## Test plan
- K=2, N=4, L=15; lines 987654321111111, 811111111111119, 234234234234278, 818181911112111 -> line_value 98, 89, 78, 92; out_sum=357.
- Same lines with K=12 -> line_value 987654321111, 811111111119, 434234234278, 888911112111; out_sum=3121910778619.
- cfg K=0, then K=13 with L=12 -> err=1, cfg_ready stays 1, in_ready stays 0. A valid cfg then clears err.
- Digit 0xA in a line of 1111 (K=2) -> err=1, digit treated as 0, line_value=11.
- rst pulsed mid-line during EVAL pops -> all outputs at reset values next cycle. A fresh K=2 run on 987654321111111 gives 98.
- out_ready held low 50 cycles in DONE -> out_valid and out_sum stable throughout; returns to IDLE one cycle after out_ready rises.
